// File: rtl/latch_bank.sv
// Multi-channel double-buffered enable latch: per-channel shadows, atomic commit,
// lock to freeze outputs, and a coalescing valid/ready change report.

module latch_lane #(
   parameter int                   DATA_SIZE = 5,
   parameter logic [DATA_SIZE-1:0] RESET_VAL = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [DATA_SIZE-1:0] wr_data,
   input  logic                 apply,
   output logic                 chg,
   output logic [DATA_SIZE-1:0] data_out
);
   logic [DATA_SIZE-1:0] shadow;

   // chg compares the pre-write shadow, so a same-cycle write never counts
   assign chg = (shadow != data_out);

   always_ff @(posedge clk) begin
      if (!rst) begin
         shadow   <= RESET_VAL;
         data_out <= RESET_VAL;
      end else begin
         if (wr_en) shadow   <= wr_data;
         if (apply) data_out <= shadow;
      end
   end
endmodule

module latch_bank #(
   parameter int                   DATA_SIZE = 5,
   parameter int                   CHANNELS  = 4,
   parameter logic [DATA_SIZE-1:0] RESET_VAL = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [CHANNELS-1:0]           wr_en,
   input  logic [CHANNELS*DATA_SIZE-1:0] wr_data,
   input  logic                          commit,
   input  logic                          lock_set,
   input  logic                          lock_clr,
   output logic [CHANNELS*DATA_SIZE-1:0] data_out,
   output logic                          upd_valid,
   input  logic                          upd_ready,
   output logic [CHANNELS-1:0]           upd_mask,
   output logic                          locked,
   output logic                          dropped
);
   typedef enum logic {IDLE, PEND} state_t;

   state_t              state;
   logic [CHANNELS-1:0] chg;
   logic [CHANNELS-1:0] kept_mask;
   logic                apply;
   logic                accept;

   assign apply     = commit & ~locked;
   assign accept    = upd_valid & upd_ready;
   assign kept_mask = accept ? '0 : upd_mask;
   assign upd_valid = (state == PEND);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      latch_lane #(.DATA_SIZE(DATA_SIZE), .RESET_VAL(RESET_VAL)) u_lane (
         .clk      (clk),
         .rst      (rst),
         .wr_en    (wr_en[g]),
         .wr_data  (wr_data[g*DATA_SIZE +: DATA_SIZE]),
         .apply    (apply),
         .chg      (chg[g]),
         .data_out (data_out[g*DATA_SIZE +: DATA_SIZE])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         upd_mask <= '0;
         locked   <= 1'b0;
         dropped  <= 1'b0;
      end else begin
         dropped <= commit & locked;
         if (lock_set)      locked <= 1'b1;
         else if (lock_clr) locked <= 1'b0;
         // a new change wins over acceptance so no update is ever lost
         if (apply && (chg != '0)) begin
            state    <= PEND;
            upd_mask <= chg | kept_mask;
         end else if (accept) begin
            state    <= IDLE;
            upd_mask <= '0;
         end
      end
   end
endmodule

// File: tb/tb_latch_bank.sv
// Directed-vector bench for latch_bank with default parameters (5 bits x 4 channels).

module tb_latch_bank;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  wr_en;
   logic [19:0] wr_data;
   logic        commit, lock_set, lock_clr, upd_ready;
   logic [19:0] data_out;
   logic        upd_valid, locked, dropped;
   logic [3:0]  upd_mask;
   int          n_chk = 0;
   int          n_fail = 0;

   latch_bank dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .commit(commit),
      .lock_set(lock_set), .lock_clr(lock_clr), .data_out(data_out),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_mask(upd_mask),
      .locked(locked), .dropped(dropped)
   );

   always #5 clk = ~clk;

   function automatic logic [19:0] pk(input logic [4:0] c3, c2, c1, c0);
      return {c3, c2, c1, c0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wr_en = 4'b0; wr_data = '0; commit = 0; lock_set = 0; lock_clr = 0; upd_ready = 0;
   endtask

   task automatic test_reset();
      rst = 0; idle_inputs();
      tick(); tick();
      rst = 1;
      n_chk++; if (data_out !== 20'h0) begin n_fail++; $display("FAIL reset_data got %h exp %h", data_out, 20'h0); end
      n_chk++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", upd_valid); end
      n_chk++; if (upd_mask !== 4'b0) begin n_fail++; $display("FAIL reset_mask got %b exp 0000", upd_mask); end
      n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b exp 0", locked); end
      n_chk++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL reset_dropped got %b exp 0", dropped); end
   endtask

   task automatic test_commit_handshake();
      wr_en = 4'b0001; wr_data = pk(0, 0, 0, 9);
      tick();
      wr_en = 0;
      n_chk++; if (data_out !== 20'h0) begin n_fail++; $display("FAIL shadow_hidden got %h exp %h", data_out, 20'h0); end
      commit = 1;
      tick();
      commit = 0;
      n_chk++; if (data_out !== pk(0, 0, 0, 9)) begin n_fail++; $display("FAIL commit_data got %h exp %h", data_out, pk(0, 0, 0, 9)); end
      n_chk++; if (upd_valid !== 1'b1) begin n_fail++; $display("FAIL commit_valid got %b exp 1", upd_valid); end
      n_chk++; if (upd_mask !== 4'b0001) begin n_fail++; $display("FAIL commit_mask got %b exp 0001", upd_mask); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_chk++;
         if (upd_valid !== 1'b1 || upd_mask !== 4'b0001 || data_out !== pk(0, 0, 0, 9)) begin
            n_fail++; $display("FAIL hold_stable cyc %0d got v=%b m=%b d=%h exp v=1 m=0001 d=%h", i, upd_valid, upd_mask, data_out, pk(0, 0, 0, 9));
         end
      end
      upd_ready = 1;
      tick();
      upd_ready = 0;
      n_chk++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL accept_valid got %b exp 0", upd_valid); end
      n_chk++; if (upd_mask !== 4'b0) begin n_fail++; $display("FAIL accept_mask got %b exp 0000", upd_mask); end
   endtask

   task automatic test_coalesce();
      // pending 0001 then a ch2 change while not accepted
      wr_en = 4'b0001; wr_data = pk(0, 0, 0, 10); tick();
      wr_en = 0; commit = 1; tick(); commit = 0;
      wr_en = 4'b0100; wr_data = pk(0, 3, 0, 0); tick();
      wr_en = 0; commit = 1; tick(); commit = 0;
      n_chk++; if (upd_mask !== 4'b0101) begin n_fail++; $display("FAIL coalesce_mask got %b exp 0101", upd_mask); end
      n_chk++; if (upd_valid !== 1'b1) begin n_fail++; $display("FAIL coalesce_valid got %b exp 1", upd_valid); end
      n_chk++; if (data_out !== pk(0, 3, 0, 10)) begin n_fail++; $display("FAIL coalesce_data got %h exp %h", data_out, pk(0, 3, 0, 10)); end
      upd_ready = 1; tick(); upd_ready = 0;
      // same again, but the new commit lands on the accepting edge
      wr_en = 4'b0001; wr_data = pk(0, 0, 0, 11); tick();
      wr_en = 0; commit = 1; tick(); commit = 0;
      wr_en = 4'b0100; wr_data = pk(0, 5, 0, 0); tick();
      wr_en = 0; commit = 1; upd_ready = 1; tick(); commit = 0; upd_ready = 0;
      n_chk++; if (upd_mask !== 4'b0100) begin n_fail++; $display("FAIL commit_accept_mask got %b exp 0100", upd_mask); end
      n_chk++; if (upd_valid !== 1'b1) begin n_fail++; $display("FAIL commit_accept_valid got %b exp 1", upd_valid); end
      upd_ready = 1; tick(); upd_ready = 0;
      n_chk++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL coalesce_drain got %b exp 0", upd_valid); end
   endtask

   task automatic test_lock();
      lock_set = 1; tick(); lock_set = 0;
      n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_set got %b exp 1", locked); end
      wr_en = 4'b0010; wr_data = pk(0, 0, 7, 0); tick(); wr_en = 0;
      commit = 1; tick(); commit = 0;
      n_chk++; if (dropped !== 1'b1) begin n_fail++; $display("FAIL dropped_pulse got %b exp 1", dropped); end
      n_chk++; if (data_out !== pk(0, 5, 0, 11)) begin n_fail++; $display("FAIL locked_data got %h exp %h", data_out, pk(0, 5, 0, 11)); end
      n_chk++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL locked_valid got %b exp 0", upd_valid); end
      lock_clr = 1; tick(); lock_clr = 0;
      n_chk++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL dropped_width got %b exp 0", dropped); end
      n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_clr got %b exp 0", locked); end
      commit = 1; tick(); commit = 0;
      n_chk++; if (data_out !== pk(0, 5, 7, 11)) begin n_fail++; $display("FAIL unlock_data got %h exp %h", data_out, pk(0, 5, 7, 11)); end
      n_chk++; if (upd_mask !== 4'b0010) begin n_fail++; $display("FAIL unlock_mask got %b exp 0010", upd_mask); end
      upd_ready = 1; tick(); upd_ready = 0;
   endtask

   task automatic test_same_cycle_write();
      wr_en = 4'b1000; wr_data = pk(4, 0, 0, 0); commit = 1;
      tick(); wr_en = 0; commit = 0;
      n_chk++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL samecyc_valid got %b exp 0", upd_valid); end
      n_chk++; if (data_out !== pk(0, 5, 7, 11)) begin n_fail++; $display("FAIL samecyc_data got %h exp %h", data_out, pk(0, 5, 7, 11)); end
      commit = 1; tick(); commit = 0;
      n_chk++; if (data_out !== pk(4, 5, 7, 11)) begin n_fail++; $display("FAIL samecyc_next_data got %h exp %h", data_out, pk(4, 5, 7, 11)); end
      n_chk++; if (upd_mask !== 4'b1000) begin n_fail++; $display("FAIL samecyc_next_mask got %b exp 1000", upd_mask); end
      upd_ready = 1; tick(); upd_ready = 0;
   endtask

   task automatic test_lock_both_and_reset();
      lock_set = 1; lock_clr = 1; tick(); lock_set = 0; lock_clr = 0;
      n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_both got %b exp 1", locked); end
      lock_clr = 1; tick(); lock_clr = 0;
      // commit with lock_set: this commit still applies
      wr_en = 4'b0001; wr_data = pk(0, 0, 0, 1); tick(); wr_en = 0;
      commit = 1; lock_set = 1; tick(); commit = 0; lock_set = 0;
      n_chk++; if (data_out !== pk(4, 5, 7, 1) || upd_mask !== 4'b0001 || locked !== 1'b1) begin
         n_fail++; $display("FAIL commit_lockset got d=%h m=%b l=%b exp d=%h m=0001 l=1", data_out, upd_mask, locked, pk(4, 5, 7, 1));
      end
      // locked commit during a pending update leaves the update untouched
      wr_en = 4'b0010; wr_data = pk(0, 0, 2, 0); tick(); wr_en = 0;
      commit = 1; tick(); commit = 0;
      n_chk++; if (upd_valid !== 1'b1 || upd_mask !== 4'b0001 || dropped !== 1'b1) begin
         n_fail++; $display("FAIL locked_pending got v=%b m=%b dr=%b exp v=1 m=0001 dr=1", upd_valid, upd_mask, dropped);
      end
      rst = 0; tick(); rst = 1;
      n_chk++; if (data_out !== 20'h0 || upd_valid !== 1'b0 || upd_mask !== 4'b0 || locked !== 1'b0 || dropped !== 1'b0) begin
         n_fail++; $display("FAIL midreset got d=%h v=%b m=%b l=%b dr=%b exp all 0", data_out, upd_valid, upd_mask, locked, dropped);
      end
      // shadows were reset too, so a commit now has nothing to report
      commit = 1; tick(); commit = 0;
      n_chk++; if (upd_valid !== 1'b0 || data_out !== 20'h0) begin
         n_fail++; $display("FAIL post_reset_commit got v=%b d=%h exp v=0 d=%h", upd_valid, data_out, 20'h0);
      end
   endtask

   initial begin
      test_reset();
      test_commit_handshake();
      test_coalesce();
      test_lock();
      test_same_cycle_write();
      test_lock_both_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
